// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected output path: default widths
// and the writeback FSM state encoding.
package fc_pkg;

  localparam int FC_DATA_WIDTH   = 16;
  localparam int FC_ACC_WIDTH    = 32;
  localparam int FC_TILING_SIZE  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : fc_pkg

// File: rtl/out_writeback_sat_round.sv
// Per-lane quantiser: round half up, arithmetic right shift, saturate to the
// signed output range, then optional ReLU on the saturated value.
module sat_round
  import fc_pkg::*;
#(
  parameter int ACC_WIDTH  = FC_ACC_WIDTH,
  parameter int DATA_WIDTH = FC_DATA_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic [DATA_WIDTH-1:0] q
);

  // One guard bit so the rounding add can never overflow.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0]  ext;
  logic signed [ACC_WIDTH:0]  rnd;
  logic signed [ACC_WIDTH:0]  sum;
  logic signed [ACC_WIDTH:0]  shifted;
  logic        [DATA_WIDTH-1:0] sat;

  // Round, shift, clamp to the output range and apply ReLU last.
  always_comb begin
    ext = {acc[ACC_WIDTH-1], acc};
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = (ACC_WIDTH+1)'(1) << (shift - 5'd1);
    end
    sum     = ext + rnd;
    shifted = sum >>> shift;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = shifted[DATA_WIDTH-1:0];
    end
    q = sat;
    if (relu_en && sat[DATA_WIDTH-1]) begin
      q = '0;
    end
  end

endmodule : sat_round

// File: rtl/out_writeback.sv
// Tile writeback: captures a tile of accumulators on start, then streams one
// quantised lane per accepted memory write and pulses done at the end.
module out_writeback
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = FC_DATA_WIDTH,
  parameter int TILING_SIZE = FC_TILING_SIZE,
  parameter int ACC_WIDTH   = FC_ACC_WIDTH,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          tile_base,
  input  logic [TILING_SIZE*ACC_WIDTH-1:0] acc_in,
  input  logic [4:0]                     shift,
  input  logic                           relu_en,
  input  logic                           mem_ready,
  output logic                           mem_wr_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic                           busy,
  output logic                           done
);

  localparam int IDX_W = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILING_SIZE - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [ACC_WIDTH-1:0]   lanes_q [TILING_SIZE];
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic [DATA_WIDTH-1:0]  lane_q;
  logic                   capture;
  logic                   accept;

  assign capture = (state_q == IDLE) && start;
  assign accept  = (state_q == WRITE) && mem_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (mem_ready && (idx_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tile capture and lane index; captured values stay frozen until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILING_SIZE; i++) begin
        lanes_q[i] <= '0;
      end
      base_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      idx_q   <= '0;
    end else if (capture) begin
      for (int i = 0; i < TILING_SIZE; i++) begin
        lanes_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
      end
      base_q  <= tile_base;
      shift_q <= shift;
      relu_q  <= relu_en;
      idx_q   <= '0;
    end else if (accept) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  sat_round #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_round (
    .acc     (lanes_q[idx_q]),
    .shift   (shift_q),
    .relu_en (relu_q),
    .q       (lane_q)
  );

  // Outputs decode purely from registered state; address and data idle at zero.
  assign mem_wr_en = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_addr  = mem_wr_en ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
  assign mem_wdata = mem_wr_en ? lane_q : '0;

endmodule : out_writeback

// File: tb/tb_out_writeback.sv
// Directed self-checking bench for out_writeback with default parameters.
module tb_out_writeback;

  localparam int TS  = 8;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int ADW = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADW-1:0]    tile_base;
  logic [TS*AW-1:0]  acc_in;
  logic [4:0]        shift;
  logic              relu_en;
  logic              mem_ready;
  logic              mem_wr_en;
  logic [ADW-1:0]    mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  out_writeback #(
    .DATA_WIDTH  (DW),
    .TILING_SIZE (TS),
    .ACC_WIDTH   (AW),
    .ADDR_WIDTH  (ADW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tile_base (tile_base),
    .acc_in    (acc_in),
    .shift     (shift),
    .relu_en   (relu_en),
    .mem_ready (mem_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle with the given tile; returns in the first WRITE cycle.
  task automatic launch(input logic [ADW-1:0] base, input logic [4:0] sh,
                        input logic rl, input logic [TS*AW-1:0] acc);
    tile_base = base;
    shift     = sh;
    relu_en   = rl;
    acc_in    = acc;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({mem_wr_en, mem_addr, mem_wdata, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got wr=%b addr=%h data=%h busy=%b done=%b expected all zero",
               mem_wr_en, mem_addr, mem_wdata, busy, done);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_wait: got busy=%b wr=%b expected 0 0", busy, mem_wr_en);
    end
  endtask

  task automatic test_basic();
    logic [TS*AW-1:0] acc;
    logic [ADW-1:0]   exp_addr;
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = AW'(i + 1);
    launch(16'h0010, 5'd0, 1'b0, acc);
    for (int i = 0; i < TS; i++) begin
      exp_addr = 16'h0010 + 16'(i);
      checks++;
      if (mem_wr_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_ctrl lane %0d: got wr=%b busy=%b done=%b expected 1 1 0",
                 i, mem_wr_en, busy, done);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL basic_addr lane %0d: got %h expected %h", i, mem_addr, exp_addr);
      end
      checks++;
      if (mem_wdata !== 16'(i + 1)) begin
        errors++;
        $display("[TB] FAIL basic_data lane %0d: got %h expected %h", i, mem_wdata, 16'(i + 1));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || mem_wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done: got done=%b wr=%b busy=%b expected 1 0 1", done, mem_wr_en, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_after_done: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_round_sat();
    logic [AW-1:0]    vals [TS];
    logic [DW-1:0]    expv [TS];
    logic [TS*AW-1:0] acc;
    vals = '{32'd5, 32'd6, 32'hFFFF_FFFA, 32'h7FFF_FFFF, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 32'd0};
    expv = '{16'h0001, 16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h0000};
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = vals[i];
    launch(16'h0040, 5'd2, 1'b0, acc);
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (mem_wdata !== expv[i]) begin
        errors++;
        $display("[TB] FAIL round_sat_data lane %0d: got %h expected %h", i, mem_wdata, expv[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL round_sat_done: got %b expected 1", done);
    end
    step();
  endtask

  task automatic test_relu();
    logic [AW-1:0]    vals [TS];
    logic [DW-1:0]    exp_on [TS];
    logic [DW-1:0]    exp_off [TS];
    logic [TS*AW-1:0] acc;
    vals    = '{-32'sd300, 32'd300, 32'hFFFF_FFFF, 32'd0, 32'd70000, -32'sd70000, 32'd5, -32'sd5};
    exp_on  = '{16'h0000, 16'h012C, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0005, 16'h0000};
    exp_off = '{16'hFED4, 16'h012C, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFFB};
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = vals[i];
    launch(16'h0080, 5'd0, 1'b1, acc);
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (mem_wdata !== exp_on[i]) begin
        errors++;
        $display("[TB] FAIL relu_on_data lane %0d: got %h expected %h", i, mem_wdata, exp_on[i]);
      end
      step();
    end
    step();
    launch(16'h0080, 5'd0, 1'b0, acc);
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (mem_wdata !== exp_off[i]) begin
        errors++;
        $display("[TB] FAIL relu_off_data lane %0d: got %h expected %h", i, mem_wdata, exp_off[i]);
      end
      step();
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [TS*AW-1:0] acc;
    logic [ADW-1:0]   exp_addr;
    int               cyc;
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = AW'(100 + i);
    launch(16'h0100, 5'd0, 1'b0, acc);
    cyc = 1;
    for (int i = 0; i < TS; i++) begin
      exp_addr = 16'h0100 + 16'(i);
      if (i == 3) begin
        mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (mem_wr_en !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 16'(100 + i) || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_hold cycle %0d: got wr=%b addr=%h data=%h done=%b expected 1 %h %h 0",
                     s, mem_wr_en, mem_addr, mem_wdata, done, exp_addr, 16'(100 + i));
          end
          step();
          cyc++;
        end
        mem_ready = 1'b1;
      end
      checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 16'(100 + i)) begin
        errors++;
        $display("[TB] FAIL stall_lane %0d: got wr=%b addr=%h data=%h expected 1 %h %h",
                 i, mem_wr_en, mem_addr, mem_wdata, exp_addr, 16'(100 + i));
      end
      step();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_done at cycle %0d after start: got %b expected 1", cyc, done);
    end
    step();
  endtask

  task automatic test_wrap_ignored_start();
    logic [TS*AW-1:0] acc;
    logic [ADW-1:0]   exp_addr;
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = AW'(1000 + 7 * i);
    launch(16'hFFFE, 5'd0, 1'b0, acc);
    for (int i = 0; i < TS; i++) begin
      exp_addr = 16'hFFFE + 16'(i);
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL wrap_addr lane %0d: got %h expected %h", i, mem_addr, exp_addr);
      end
      checks++;
      if (mem_wdata !== 16'(1000 + 7 * i)) begin
        errors++;
        $display("[TB] FAIL wrap_data lane %0d: got %h expected %h", i, mem_wdata, 16'(1000 + 7 * i));
      end
      if (i == 2) begin
        start     = 1'b1;
        tile_base = 16'h1234;
        acc_in    = '1;
        shift     = 5'd4;
        relu_en   = 1'b1;
      end
      step();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_done: got %b expected 1", done);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_tile();
    logic [TS*AW-1:0] acc;
    logic [ADW-1:0]   exp_addr;
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = AW'(i + 1);
    launch(16'h0200, 5'd0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (mem_addr !== 16'h0204 || mem_wdata !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL midreset_position: got addr=%h data=%h expected 0204 0005", mem_addr, mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wr_en, mem_addr, mem_wdata, busy, done} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got wr=%b addr=%h data=%h busy=%b done=%b expected all zero",
               mem_wr_en, mem_addr, mem_wdata, busy, done);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_no_done cycle %0d: got done=%b busy=%b expected 0 0", c, done, busy);
      end
    end
    for (int i = 0; i < TS; i++) acc[i*AW +: AW] = AW'(21 + i);
    launch(16'h0300, 5'd0, 1'b0, acc);
    for (int i = 0; i < TS; i++) begin
      exp_addr = 16'h0300 + 16'(i);
      checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 16'(21 + i)) begin
        errors++;
        $display("[TB] FAIL postreset_lane %0d: got wr=%b addr=%h data=%h expected 1 %h %h",
                 i, mem_wr_en, mem_addr, mem_wdata, exp_addr, 16'(21 + i));
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL postreset_done: got %b expected 1", done);
    end
    step();
  endtask

  initial begin
    start     = 1'b0;
    tile_base = '0;
    acc_in    = '0;
    shift     = '0;
    relu_en   = 1'b0;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    test_reset();
    test_basic();
    test_round_sat();
    test_relu();
    test_backpressure();
    test_wrap_ignored_start();
    test_reset_mid_tile();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_out_writeback
